// File: rtl/hadamard_satd_4x4.sv
// hadamard_satd_4x4: 2-D 4x4 Hadamard SATD of signed differences, one row per beat, valid/ready result
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_row : row beat of four DIFF_W signed differences, d0 in LSBs
//   out_valid/out_ready/satd : block SATD, held until accepted
//   busy                     : high unless idle in LOAD with no rows taken
//   SATD_HALF_EN             : when defined, satd = (sum+1)>>1 instead of the raw sum
module hadamard_satd_4x4 #(
  parameter int DIFF_W = 9,
  parameter int SUM_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIFF_W-1:0]   in_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SUM_W-1:0]      satd,
  output logic                  busy
);
  localparam int RW = DIFF_W + 2;
  localparam int CW = DIFF_W + 4;
  typedef enum logic [1:0] {LOAD, COL, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [SUM_W-1:0] acc, acc_nx, res;
  logic signed [RW-1:0] tbuf [4][4];
  logic signed [DIFF_W-1:0] d [4];
  logic signed [CW-1:0] hc [4];
  logic [CW-1:0] a [4];
  logic [4*CW-1:0] hr_p, hc_p;
  // Same butterfly for rows and columns; everything is carried at column width so no width juggling.
  function automatic logic [4*CW-1:0] bfly(input logic signed [CW-1:0] x0, x1, x2, x3);
    logic signed [CW-1:0] s0, s1, s2, s3;
    s0 = x0 + x1;
    s1 = x0 - x1;
    s2 = x2 + x3;
    s3 = x2 - x3;
    return {s1 - s3, s0 - s2, s1 + s3, s0 + s2};
  endfunction
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign d[i] = in_row[i*DIFF_W +: DIFF_W];
    assign hc[i] = hc_p[i*CW +: CW];
    assign a[i] = hc[i][CW-1] ? -hc[i] : hc[i];
  end
  assign hr_p = bfly(CW'(d[0]), CW'(d[1]), CW'(d[2]), CW'(d[3]));
  assign hc_p = bfly(CW'(tbuf[0][cnt]), CW'(tbuf[1][cnt]), CW'(tbuf[2][cnt]), CW'(tbuf[3][cnt]));
  assign acc_nx = acc + SUM_W'(a[0]) + SUM_W'(a[1]) + SUM_W'(a[2]) + SUM_W'(a[3]);
`ifdef SATD_HALF_EN
  assign res = SUM_W'(({1'b0, acc_nx} + (SUM_W+1)'(1)) >> 1);
`else
  assign res = acc_nx;
`endif
  assign in_ready = state == LOAD;
  assign out_valid = state == DONE;
  assign busy = !(state == LOAD && cnt == 2'd0);
  always_comb begin
    state_nx = (state == LOAD && in_valid && cnt == 2'd3) ? COL :
               (state == COL && cnt == 2'd3) ? DONE :
               (state == DONE && out_ready) ? LOAD : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
      cnt <= '0;
      acc <= '0;
      satd <= '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tbuf[r][c] <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD && in_valid) begin
        for (int k = 0; k < 4; k++)
          tbuf[cnt][k] <= RW'(hr_p[k*CW +: CW]);
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) acc <= '0;
      end
      if (state == COL) begin
        acc <= acc_nx;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) satd <= res;
      end
    end
  end
endmodule

// File: tb/tb_hadamard_satd_4x4.sv
// tb_hadamard_satd_4x4: directed and randomized blocks checked against a matrix-form Hadamard SATD model
module tb_hadamard_satd_4x4;
  localparam int DW = 9;
  localparam int SW = 16;
  typedef int blk_t [4][4];
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4*DW-1:0] in_row;
  logic [SW-1:0] satd;
  int checks = 0;
  int failures = 0;
  blk_t b;
  always #5 clk = ~clk;
  hadamard_satd_4x4 #(.DIFF_W(DW), .SUM_W(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .satd(satd), .busy(busy)
  );
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int model(blk_t m);
    int h [4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};
    int s = 0;
    for (int u = 0; u < 4; u++)
      for (int v = 0; v < 4; v++) begin
        int c = 0;
        for (int r = 0; r < 4; r++)
          for (int k = 0; k < 4; k++)
            c += h[u][r] * h[v][k] * m[r][k];
        s += (c < 0) ? -c : c;
      end
`ifdef SATD_HALF_EN
    return (s + 1) >> 1;
`else
    return s;
`endif
  endfunction
  function automatic logic [4*DW-1:0] pack(blk_t m, int r);
    logic [4*DW-1:0] p;
    for (int k = 0; k < 4; k++) p[k*DW +: DW] = DW'(m[r][k]);
    return p;
  endfunction
  task automatic run_block(string tag, blk_t m, int gap, int hold);
    int w;
    int exp = model(m);
    out_ready = 1'($urandom_range(0, 1));
    for (int r = 0; r < 4; r++) begin
      if (r > 0)
        repeat (gap) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      in_valid = 1'b1;
      in_row = pack(m, r);
      w = 0;
      while (!in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready) check({tag, " in_ready_timeout"}, 0, 1);
      @(posedge clk); #1;
      if (r == 0) check({tag, " busy"}, busy, 1);
    end
    in_valid = 1'b0;
    out_ready = (hold == 0);
    for (int i = 0; i < 4; i++) begin
      check({tag, " early_valid"}, out_valid, 0);
      @(posedge clk); #1;
    end
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " satd"}, satd, exp);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check({tag, " hold_valid"}, out_valid, 1);
        check({tag, " hold_satd"}, satd, exp);
        check({tag, " hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, " valid_drop"}, out_valid, 0);
    check({tag, " in_ready_back"}, in_ready, 1);
    out_ready = 1'b0;
  endtask
  task automatic fill(int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = v;
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_row = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst satd", satd, 0);
    check("rst busy", busy, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    fill(0);
    run_block("zero", b, 0, 0);
    fill(1);
    run_block("ones", b, 0, 0);
    fill(255);
    run_block("pos255", b, 0, 0);
    fill(-255);
    run_block("neg255", b, 0, 0);
    fill(0);
    b[0][0] = 1;
    run_block("impulse", b, 0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = ((r + c) % 2 == 0) ? 255 : -255;
    run_block("checker_gap", b, 1, 0);
    run_block("checker_hold", b, 0, 10);
    fill(7);
    in_valid = 1'b1;
    in_row = pack(b, 0);
    @(posedge clk); #1;
    in_row = pack(b, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("partial busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("async in_ready", in_ready, 1);
    check("async busy", busy, 0);
    check("async out_valid", out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      check("post_rst no_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    fill(1);
    run_block("after_rst", b, 0, 0);
    for (int n = 0; n < 20; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) b[r][c] = int'($urandom_range(0, 510)) - 255;
      run_block("rand", b, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hadamard_satd_4x4.md
Name: hadamard_satd_4x4

Overview:
- Downstream neighbour of the per-pixel difference stage in the SATD datapath.
- Consumes one 4x4 block of signed ORG-CUR differences, one row per accepted beat.
- Applies a 2-D 4-point Hadamard transform: rows on entry, columns from an internal transpose buffer.
- Accumulates the absolute values of all 16 coefficients and presents the block SATD with a valid/ready handshake.

Parameters:
- DIFF_W, 9, width of each signed difference input (8-bit minus 8-bit)
- SUM_W, 16, width of the SATD result (16 x max |coeff| 4080 = 65280 fits)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  row beat valid
- in_ready  output  1  block accepts a row this cycle
- in_row  input  4*DIFF_W  signed differences d0..d3; d0 in the LSBs
- out_valid  output  1  SATD result valid
- out_ready  input  1  consumer accepts result
- satd  output  SUM_W  block SATD, unsigned
- busy  output  1  high in any state other than LOAD with row count 0

Behaviour:
- Reset values: in_ready=1, out_valid=0, satd=0, busy=0. State is LOAD, row count 0, accumulator 0, transpose buffer 0.
- FSM states: LOAD, COL, DONE.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, compute the row transform combinationally and store 4 coefficients (11-bit signed) in buffer row[cnt].
  - Row transform: s0=d0+d1, s1=d0-d1, s2=d2+d3, s3=d2-d3; h0=s0+s2, h1=s1+s3, h2=s0-s2, h3=s1-s3.
  - cnt increments 0..3. On the 4th accepted row, go to COL with cnt=0 and clear the accumulator.
  - in_valid low: hold; no timeout.
- COL:
  - in_ready=0.
  - One column per cycle, cnt=0..3. Apply the same butterfly to buffer[0..3][cnt], giving 13-bit signed coefficients.
  - Add the sum of their 4 absolute values (each fits 12 bits unsigned) into the accumulator.
  - After column 3, go to DONE and register satd.
- DONE:
  - out_valid=1 and satd stable until out_ready is sampled high.
  - On that cycle: out_valid drops next cycle, go to LOAD with cnt=0.
  - in_ready stays 0 in DONE. No overlap with the next block.
- Latency: 4th row accepted at edge N → out_valid high after edge N+4. Minimum block period 9 cycles with out_ready tied high.
- Arithmetic:
  - All intermediates are sign-extended before add/subtract. No saturation is needed at these widths.
  - abs(-x) uses two's complement negate on the 13-bit value; -4080 is representable.
- Boundary cases:
  - Reset asserted mid-block (any state): immediate return to reset values; a partial block is discarded, never emitted.
  - out_ready high while out_valid low: ignored.
  - in_valid high outside LOAD: ignored; the row is not consumed and the producer must hold it.
- busy is used by the top-level control to sequence the diff enables.

Optional Feature:
- Macro: SATD_HALF_EN.
- Defined: the DONE transition registers satd=(acc+1)>>1 (HEVC 4x4 normalisation); satd upper bit is then always 0.
- Undefined: satd=acc, raw sum of |coefficients|.
- Handshake and latency are identical in both builds.

Test Plan:
- All 16 differences 0, out_ready=1 → satd=0, out_valid exactly 1 cycle, 4 cycles after the 4th row.
- All differences +1 → only DC=16 → satd=16 (SATD_HALF_EN: 8). Repeat with all +255 → satd=4080 (HALF: 2040); all -255 → 4080.
- Single difference d0 of row 0 = +1, rest 0 → all 16 coefficients ±1 → satd=16 (HALF: 8).
- Checkerboard ±255 (row r, col c sign=(-1)^(r+c)) → one coefficient ±4080 → satd=4080. in_valid toggled between rows → result unchanged.
- out_ready held 0 for 10 cycles in DONE → out_valid and satd stable, in_ready=0. Release → next block accepted the cycle after handshake.
- Reset pulsed after 2 rows, then a full all-+1 block → no spurious out_valid, result satd=16.
